// File: rtl/ssp_tx_ctrl.sv
// SSP transmit controller: pops words from the TxFIFO and sends each as a
// TI-style frame (one-bit frame sync, then DATA_W bits MSB-first) with a generated clock.
module ssp_tx_ctrl #(
    parameter int DATA_W      = 8,
    parameter int HALF_PERIOD = 1
) (
    input  logic              pclk,
    input  logic              clear,
    input  logic              sse,
    input  logic              tx_fifo_empty,
    input  logic [DATA_W-1:0] txdata,
    output logic              t_en,
    output logic              sspclkout,
    output logic              sspfssout,
    output logic              ssptxd,
    output logic              sspoe_b,
    output logic              tx_busy
);

    localparam int HC_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int BC_W = $clog2(DATA_W);
    localparam logic [HC_W-1:0] HC_MAX = HC_W'(HALF_PERIOD - 1);
    localparam logic [BC_W-1:0] BC_MAX = BC_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FSYNC = 2'd1,
        SHIFT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [HC_W-1:0]   hc_q, hc_d;
    logic              phase_q, phase_d;
    logic [BC_W-1:0]   bc_q, bc_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;

    logic sspclkout_q, sspclkout_d;
    logic sspfssout_q, sspfssout_d;
    logic ssptxd_q, ssptxd_d;
    logic sspoe_b_q, sspoe_b_d;

    logic hc_last;
    logic bit_end;
    logic word_end;
    logic pop_req;

    assign hc_last  = (hc_q == HC_MAX);
    assign bit_end  = (state_q != IDLE) && hc_last && phase_q;
    assign word_end = (state_q == SHIFT) && bit_end && (bc_q == BC_MAX);
    assign pop_req  = sse && !tx_fifo_empty && !clear;

    // Pop strobe: the head word is consumed on the rising edge that ends a
    // cycle with t_en high; there is no back-pressure from the FIFO side.
    assign t_en = pop_req && ((state_q == IDLE) || word_end);

    // State, datapath and output register
    always_ff @(posedge pclk) begin
        if (clear) begin
            state_q     <= IDLE;
            hc_q        <= '0;
            phase_q     <= 1'b0;
            bc_q        <= '0;
            shreg_q     <= '0;
            sspclkout_q <= 1'b0;
            sspfssout_q <= 1'b0;
            ssptxd_q    <= 1'b0;
            sspoe_b_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            hc_q        <= hc_d;
            phase_q     <= phase_d;
            bc_q        <= bc_d;
            shreg_q     <= shreg_d;
            sspclkout_q <= sspclkout_d;
            sspfssout_q <= sspfssout_d;
            ssptxd_q    <= ssptxd_d;
            sspoe_b_q   <= sspoe_b_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (t_en) state_d = FSYNC;
            FSYNC: if (bit_end) state_d = SHIFT;
            SHIFT: if (word_end) state_d = t_en ? FSYNC : IDLE;
            default: state_d = IDLE;
        endcase
        if (clear) state_d = IDLE;
    end

    // Counters and shift register
    always_comb begin
        hc_d    = hc_q;
        phase_d = phase_q;
        bc_d    = bc_q;
        shreg_d = shreg_q;
        if (clear) begin
            hc_d    = '0;
            phase_d = 1'b0;
            bc_d    = '0;
            shreg_d = '0;
        end else if (t_en) begin
            hc_d    = '0;
            phase_d = 1'b0;
            bc_d    = '0;
            shreg_d = txdata;
        end else if (state_q != IDLE) begin
            if (hc_last) begin
                hc_d    = '0;
                phase_d = !phase_q;
                if (bit_end && (state_q == SHIFT)) begin
                    bc_d    = word_end ? '0 : bc_q + BC_W'(1);
                    shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                end
            end else begin
                hc_d = hc_q + HC_W'(1);
            end
        end
    end

    // Output logic: computed from next state so the pads come straight from flops
    always_comb begin
        sspclkout_d = (state_d != IDLE) && !phase_d;
        sspfssout_d = (state_d == FSYNC);
        ssptxd_d    = (state_d == SHIFT) && shreg_d[DATA_W-1];
        sspoe_b_d   = (state_d == IDLE);
    end

    assign sspclkout = sspclkout_q;
    assign sspfssout = sspfssout_q;
    assign ssptxd    = ssptxd_q;
    assign sspoe_b   = sspoe_b_q;
    assign tx_busy   = (state_q != IDLE);

endmodule
